// File: rtl/psram_weight_writer.sv
// psram_weight_writer
//   Packs ACTIV_BITS-wide weight/bias words little-endian into 32-bit beats.
//   Each beat is written to PSRAM as one controller transfer. A write that
//   gets no completion within TIMEOUT_CYCLES aborts the job.
//   Word n lands at byte address base_addr + n*(ACTIV_BITS/8).
module psram_weight_writer #(
  parameter int ACTIV_BITS     = 16,
  parameter int COUNT_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [23:0]           base_addr,
  input  logic [COUNT_BITS-1:0] num_words,
  input  logic [ACTIV_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [23:0]           psram_addr,
  output logic [31:0]           psram_data_i,
  output logic [2:0]            psram_size,
  output logic                  psram_start,
  output logic [7:0]            psram_cmd,
  output logic                  psram_rd_wr,
  input  logic                  psram_done
);

  localparam int WPB    = 32 / ACTIV_BITS;          // words per beat
  localparam int BPW    = ACTIV_BITS / 8;           // bytes per word
  localparam int LANE_W = (WPB > 2) ? 2 : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [23:0]           base_q, base_d;
  logic [COUNT_BITS-1:0] num_q, num_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [21:0]           beat_q, beat_d;
  logic [31:0]           pack_q, pack_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [23:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [2:0]            size_q, size_d;
  logic                  start_q, start_d;

  logic [LANE_W-1:0]     lane_s;
  logic [COUNT_BITS:0]   cnt_inc_s;
  logic                  last_word_s;
  logic                  beat_full_s;
  logic                  accept_s;
  logic [2:0]            words_in_beat_s;

  // Register all state and outputs; async reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= 24'h000000;
      num_q      <= {COUNT_BITS{1'b0}};
      cnt_q      <= {COUNT_BITS{1'b0}};
      beat_q     <= 22'd0;
      pack_q     <= 32'h0000_0000;
      tmo_q      <= {TMO_W{1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= 24'h000000;
      data_q     <= 32'h0000_0000;
      size_q     <= 3'd4;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      pack_q     <= pack_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      start_q    <= start_d;
    end
  end

  // Next-state logic: collect words into a beat, issue it, await completion or timeout.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    pack_d     = pack_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    start_d    = 1'b0;

    lane_s          = cnt_q[LANE_W-1:0];
    cnt_inc_s       = {1'b0, cnt_q} + {{COUNT_BITS{1'b0}}, 1'b1};
    last_word_s     = (cnt_inc_s == {1'b0, num_q});
    beat_full_s     = (lane_s == LANE_W'(WPB - 1));
    accept_s        = in_valid & in_ready_q;
    words_in_beat_s = 3'(lane_s) + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          base_d  = base_addr;
          num_d   = num_words;
          cnt_d   = {COUNT_BITS{1'b0}};
          beat_d  = 22'd0;
          pack_d  = 32'h0000_0000;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (num_words == {COUNT_BITS{1'b0}}) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s) begin
          pack_d[int'(lane_s) * ACTIV_BITS +: ACTIV_BITS] = in_data;
          cnt_d = cnt_inc_s[COUNT_BITS-1:0];
          if (beat_full_s || last_word_s) begin
            // Latch the transfer fields now so they show up together with start.
            state_d = ST_ISSUE;
            start_d = 1'b1;
            addr_d  = base_q + {beat_q, 2'b00};
            data_d  = pack_d;
            size_d  = 3'(words_in_beat_s * 3'(BPW));
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_ISSUE: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (psram_done) begin
          beat_d = beat_q + 22'd1;
          pack_d = 32'h0000_0000;
          if (cnt_q == num_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_COLLECT);
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign psram_addr   = addr_q;
  assign psram_data_i = data_q;
  assign psram_size   = size_q;
  assign psram_start  = start_q;
  assign psram_cmd    = 8'h02;
  assign psram_rd_wr  = 1'b1;

endmodule

// File: tb/tb_psram_weight_writer.sv
// Bench for psram_weight_writer: randomized jobs, a spec-level model
// that predicts the PSRAM writes, and a monitor that checks each write
// as the DUT issues it.
module tb_psram_weight_writer;

  localparam int AB  = 16;
  localparam int CB  = 16;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [23:0]   base_addr = 24'h000000;
  logic [CB-1:0] num_words = 16'd0;
  logic [AB-1:0] in_data = 16'h0000;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [23:0]   psram_addr;
  logic [31:0]   psram_data_i;
  logic [2:0]    psram_size;
  logic          psram_start;
  logic [7:0]    psram_cmd;
  logic          psram_rd_wr;
  logic          psram_done = 1'b0;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] job_words[$];
  int          checks = 0;
  int          passes = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  logic        exp_err = 1'b0;
  int          resp_delay = 1;
  bit          hold_done = 1'b0;

  psram_weight_writer #(
    .ACTIV_BITS(AB), .COUNT_BITS(CB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .base_addr(base_addr),
    .num_words(num_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .error(error),
    .psram_addr(psram_addr), .psram_data_i(psram_data_i), .psram_size(psram_size),
    .psram_start(psram_start), .psram_cmd(psram_cmd), .psram_rd_wr(psram_rd_wr),
    .psram_done(psram_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: word i of the job sits at byte base + 2*i; each 4-byte group is one write.
  task automatic model_writes(input logic [23:0] base, input int n, input int max_beats);
    int nb;
    nb = (n + 1) / 2;
    if (nb > max_beats) nb = max_beats;
    for (int b = 0; b < nb; b++) begin
      wr_t e;
      int  cnt;
      e.data = 32'h0;
      cnt = 0;
      for (int l = 0; l < 2; l++) begin
        if (2 * b + l < n) begin
          e.data = e.data | (32'(job_words[2 * b + l]) << (16 * l));
          cnt++;
        end
      end
      e.addr = base + 24'(4 * b);
      e.size = 3'(cnt * 2);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: check every issued write against the scoreboard, and every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (psram_start) begin
          start_cnt++;
          chk("cmd", psram_cmd, 8'h02);
          chk("rd_wr", psram_rd_wr, 1'b1);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1'b1, 1'b0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", psram_addr, mon_e.addr);
            chk("wr_data", psram_data_i, mon_e.data);
            chk("wr_size", psram_size, mon_e.size);
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", busy, 1'b0);
          chk("error_at_done", error, exp_err);
        end
      end
    end
  end

  // PSRAM controller stand-in: completion pulse resp_delay cycles after start.
  initial begin
    forever begin
      @(negedge clk);
      if (psram_start && !hold_done && rst_n) begin
        repeat (resp_delay) @(negedge clk);
        psram_done = 1'b1;
        @(negedge clk);
        psram_done = 1'b0;
      end
    end
  end

  task automatic drive_words(input int limit, input bit gap, input int d0, output int acc);
    int cyc;
    cyc = 0;
    acc = 0;
    while (acc < limit && cyc < 4000 && done_cnt == d0) begin
      @(negedge clk);
      cyc++;
      in_valid = gap ? ((cyc % 2) == 1) : 1'b1;
      in_data  = job_words[acc];
      if (in_valid && in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic kick(input logic [23:0] base, input int n);
    @(negedge clk);
    cfg_start = 1'b1;
    base_addr = base;
    num_words = CB'(n);
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("error_cleared", error, 1'b0);
  endtask

  // One full job; job_words must already hold n words.
  task automatic run_job(input logic [23:0] base, input int n, input bit gap,
                         input int dly, input bit tmo);
    int d0, s0, acc, cyc;
    resp_delay = dly;
    hold_done  = tmo;
    exp_err    = tmo;
    model_writes(base, n, tmo ? 1 : 1 << 20);
    d0 = done_cnt;
    s0 = start_cnt;
    kick(base, n);
    drive_words(n, gap, d0, acc);
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("words_accepted", acc, tmo ? ((n < 2) ? n : 2) : n);
    chk("start_count", start_cnt - s0, tmo ? ((n > 0) ? 1 : 0) : (n + 1) / 2);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    hold_done = 1'b0;
  endtask

  task automatic fill_random(input int n);
    job_words.delete();
    for (int i = 0; i < n; i++) job_words.push_back(16'($urandom));
  endtask

  initial begin
    int acc, d0, n;
    logic [23:0] b;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_start", psram_start, 1'b0);
    chk("rst_size", psram_size, 3'd4);
    chk("rst_addr", psram_addr, 24'h0);
    chk("rst_data", psram_data_i, 32'h0);
    rst_n = 1'b1;

    // Two full beats: 0x00020001 @0x100, 0x00040003 @0x104.
    job_words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_job(24'h000100, 4, 1'b0, 1, 1'b0);

    // Odd count: last beat half full (data 0x0000000C, size 2).
    job_words = '{16'h000A, 16'h000B, 16'h000C};
    run_job(24'h000200, 3, 1'b0, 2, 1'b0);

    // Empty job: no writes, done right after busy.
    job_words.delete();
    run_job(24'h000300, 0, 1'b0, 1, 1'b0);

    // Gapped input, slow controller.
    fill_random(7);
    run_job(24'h001000, 7, 1'b1, 20, 1'b0);

    // Address wrap at the top of the 24-bit space.
    fill_random(8);
    run_job(24'hFFFFF8, 8, 1'b0, 3, 1'b0);

    // Timeout: error set, later job clears it.
    fill_random(4);
    run_job(24'h002000, 4, 1'b0, 1, 1'b1);
    fill_random(2);
    run_job(24'h002000, 2, 1'b0, 1, 1'b0);

    // Reset while waiting on the controller.
    fill_random(4);
    hold_done = 1'b1;
    exp_err   = 1'b0;
    model_writes(24'h003000, 4, 1);
    d0 = done_cnt;
    kick(24'h003000, 4);
    drive_words(2, 1'b0, d0, acc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_start", psram_start, 1'b0);
    chk("midrst_size", psram_size, 3'd4);
    chk("midrst_addr", psram_addr, 24'h0);
    chk("midrst_data", psram_data_i, 32'h0);
    chk("midrst_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    hold_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_no_done", done_cnt - d0, 0);
    fill_random(5);
    run_job(24'h004000, 5, 1'b0, 2, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 9);
      b = (j % 3 == 2) ? 24'hFFFFF0 : (24'($urandom) & 24'hFFFFFC);
      fill_random(n);
      run_job(b, n, 1'($urandom_range(0, 1)), $urandom_range(1, 20), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
